// File: rtl/vga_pkg.sv
// vga_pkg: shared mode encodings, colour-bar masks and default 640x480@60 timing
package vga_pkg;
  typedef enum logic [1:0] {COLOR_BAR = 2'd0, GRID = 2'd1, GRADIENT = 2'd2, EXTERNAL = 2'd3} mode_e;
  // {r,g,b} on/off per bar, bar 0 at index 0: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_MASK = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: raster counters, sync/de decode, coordinates and frame tracking
// Ports: i_clk, i_rst_n (async, active low); o_req_de/o_xpos/o_ypos/o_hs/o_vs/o_de are
// stage-1 registered decodes of the counters; o_frame_start pulses while the counters
// sit at (0,0); o_frame_cnt counts completed frames; o_load marks the edge that moves
// the counters onto (0,0), used by the top to latch the pattern mode.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_req_de,
  output logic [11:0] o_xpos,
  output logic [11:0] o_ypos,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_frame_start,
  output logic [15:0] o_frame_cnt,
  output logic        o_load
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ST = H_SYNC + H_BACK;
  localparam int V_ST = V_SYNC + V_BACK;
  logic [11:0] r_h, r_v;
  logic        r_live;
  logic        w_h_end, w_v_end, w_wrap, w_hact, w_vact, w_act;
  // r_live holds the counters at (0,0) for the first clock after reset so that
  // frame_start can be seen on that clock while still resetting to 0
  assign w_h_end = r_h == 12'(H_TOTAL - 1);
  assign w_v_end = r_v == 12'(V_TOTAL - 1);
  assign w_wrap  = r_live & w_h_end & w_v_end;
  assign w_hact  = (r_h >= 12'(H_ST)) && (r_h < 12'(H_ST + H_ACTIVE));
  assign w_vact  = (r_v >= 12'(V_ST)) && (r_v < 12'(V_ST + V_ACTIVE));
  assign w_act   = w_hact & w_vact;
  assign o_frame_start = r_live & (r_h == 12'd0) & (r_v == 12'd0);
  assign o_load = ~r_live | w_wrap;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live      <= 1'b0;
      r_h         <= '0;
      r_v         <= '0;
      o_frame_cnt <= '0;
      o_req_de    <= 1'b0;
      o_xpos      <= '0;
      o_ypos      <= '0;
      o_hs        <= ~HS_POL;
      o_vs        <= ~VS_POL;
      o_de        <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wrap) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (r_live) begin
        r_h      <= w_h_end ? '0 : r_h + 12'd1;
        r_v      <= w_h_end ? (w_v_end ? '0 : r_v + 12'd1) : r_v;
        o_req_de <= w_act;
        o_de     <= w_act;
        o_xpos   <= w_act ? r_h - 12'(H_ST) : '0;
        o_ypos   <= w_act ? r_v - 12'(V_ST) : '0;
        o_hs     <= (r_h < 12'(H_SYNC)) ? HS_POL : ~HS_POL;
        o_vs     <= (r_v < 12'(V_SYNC)) ? VS_POL : ~VS_POL;
      end
    end
  end
endmodule

// File: rtl/vga_pattern_engine.sv
// vga_pattern_engine: parametrised raster timing plus test-pattern / pass-through pixel output
// Ports: clk, rst_n (async, active low); mode selects COLOR_BAR/GRID/GRADIENT/EXTERNAL,
// latched at each frame start; ext_rgb {r,g,b} is sampled one clock after its
// req_de/xpos/ypos; vga_hs/vs/de/r/g/b lag the counters by two clocks;
// frame_start/frame_cnt track frames.
// Option: define VGA_PATTERN_SCROLL_EN to scroll GRID and GRADIENT one pixel per frame.
module vga_pattern_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int COLOR_W = 8,
  parameter int GRID_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] ext_rgb,
  output logic                 req_de,
  output logic [11:0]          xpos,
  output logic [11:0]          ypos,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start,
  output logic [15:0]          frame_cnt
);
  localparam int XW = COLOR_W > GRID_LOG2 ? COLOR_W : GRID_LOG2;
  logic               w_hs, w_vs, w_de, w_load, w_grid;
  logic [2:0]         w_bar, w_mask;
  logic [XW-1:0]      w_xs;
  logic [COLOR_W-1:0] w_sum;
  logic [3*COLOR_W-1:0] w_pix;
  mode_e              r_mode;
  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_core (
    .i_clk(clk), .i_rst_n(rst_n), .o_req_de(req_de), .o_xpos(xpos), .o_ypos(ypos),
    .o_hs(w_hs), .o_vs(w_vs), .o_de(w_de), .o_frame_start(frame_start),
    .o_frame_cnt(frame_cnt), .o_load(w_load)
  );
`ifdef VGA_PATTERN_SCROLL_EN
  assign w_xs = XW'(xpos + frame_cnt[11:0]);
`else
  assign w_xs = XW'(xpos);
`endif
  // bar index from constant boundary compares, so no divider is needed
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) if (xpos >= 12'(k * H_ACTIVE / 8)) w_bar = 3'(k);
  end
  assign w_mask = BAR_MASK[w_bar];
  assign w_grid = (w_xs[GRID_LOG2-1:0] == '0) || (ypos[GRID_LOG2-1:0] == '0);
  assign w_sum  = w_xs[COLOR_W-1:0] + ypos[COLOR_W-1:0];
  assign w_pix  = r_mode == COLOR_BAR ? {{COLOR_W{w_mask[2]}}, {COLOR_W{w_mask[1]}}, {COLOR_W{w_mask[0]}}} :
                  r_mode == GRID      ? {3*COLOR_W{w_grid}} :
                  r_mode == GRADIENT  ? {w_xs[COLOR_W-1:0], ypos[COLOR_W-1:0], w_sum} : ext_rgb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= COLOR_BAR;
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      vga_de <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      if (w_load) r_mode <= mode_e'(mode);
      vga_hs <= w_hs;
      vga_vs <= w_vs;
      vga_de <= w_de;
      {vga_r, vga_g, vga_b} <= w_de ? w_pix : '0;
    end
  end
endmodule

// File: doc/vga_pattern_engine.md
# vga_pattern_engine

Parametrised VGA/LCD raster engine combining timing generation and test-pattern synthesis in one clock domain. It generalises the fixed-resolution driver/display pair: resolution, porches, sync polarity and colour depth are parameters, and four run-time-selectable pixel modes are provided, including pass-through from an external pixel source. It sits after the pixel-clock divider and drives the panel/DAC pins directly.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porch and sync widths, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porch and sync widths, in lines
- HS_POL, 0 / VS_POL, 0: active level of the sync pulses
- COLOR_W, 8: bits per colour channel
- GRID_LOG2, 5: grid pitch is 2^GRID_LOG2 pixels
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 COLOR_BAR, 1 GRID, 2 GRADIENT, 3 EXTERNAL
- ext_rgb  in  3*COLOR_W  external pixel as {r,g,b}; sampled one cycle after its coordinate is issued
- req_de  out  1  the current xpos/ypos pair is an active pixel
- xpos / ypos  out  12 each  active-area coordinate; 0 when req_de is low
- vga_hs / vga_vs / vga_de  out  1 each  sync and data-enable, aligned with the rgb outputs
- vga_r / vga_g / vga_b  out  COLOR_W each  pixel colour
- frame_start  out  1  one-cycle pulse on the first clock of each frame, with h=0 and v=0
- frame_cnt  out  16  frames completed; wraps modulo 2^16

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT.
  - v_cnt advances when h_cnt wraps and runs 0..V_TOTAL-1.
  - Line order is sync, back porch, active, front porch.
- Sync and enable:
  - Sync is active while h_cnt < H_SYNC (horizontal) or v_cnt < V_SYNC (vertical).
  - Active region: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE), and likewise for v_cnt.
- Mode latch: `mode` is captured into mode_q only when the counters wrap to (0,0). A change mid-frame takes effect at the next frame.
- Patterns are computed on delayed coordinates x and y:
  - COLOR_BAR: 8 equal bars, with boundaries at the constants k*H_ACTIVE/8 (no divider). Colours in order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale value is all ones.
  - GRID: white when x[GRID_LOG2-1:0]==0 or y[GRID_LOG2-1:0]==0, otherwise black.
  - GRADIENT: r = x[COLOR_W-1:0], g = y[COLOR_W-1:0], b = (x+y)[COLOR_W-1:0], truncated.
  - EXTERNAL: ext_rgb passed through.
- Outside the active region rgb is forced to 0 in every mode.
- frame_cnt increments on the same clock as frame_start.

## Timing
- Stage 0 is the counters.
- Stage 1 (registered) produces req_de, xpos, ypos and the internal hs/vs/de.
- Stage 2 (registered) produces vga_* and samples ext_rgb.
- vga_hs, vga_vs, vga_de and rgb therefore lag the counter by 2 clocks and stay mutually aligned. ext_rgb must be valid exactly 1 clock after its xpos/ypos.
- Reset values:
  - counters, xpos, ypos, req_de, vga_de, rgb, frame_cnt, frame_start: 0
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL
  - mode_q = COLOR_BAR
- Reset asserted mid-frame clears everything immediately. After release the first frame_start occurs on the first clock.
- frame_cnt wraps from 0xFFFF to 0 without a glitch on frame_start.

## Configuration
- Macro: VGA_PATTERN_SCROLL_EN.
- Defined: GRID and GRADIENT use x + frame_cnt[11:0] (12-bit wrap) in place of x, so the pattern scrolls one pixel per frame. COLOR_BAR and EXTERNAL are unaffected.
- Undefined: the adder is removed and patterns are static. All other behaviour is identical.

## Structure
- Package vga_pkg holds:
  - the mode encodings (COLOR_BAR, GRID, GRADIENT, EXTERNAL)
  - the eight colour-bar constants as 3-bit on/off masks
  - default 640x480@60 timing constants
- Sub-module vga_timing_core holds the counters, sync/de decode, xpos/ypos and frame_start/frame_cnt. The top level adds the mode latch, the pattern mux and stage 2.

## Test plan
Bench parameters: H 16/2/2/2 (H_TOTAL 22), V 8/1/1/1 (V_TOTAL 11), COLOR_W 8. One frame is 242 clocks.

- Reset released → vga_hs=1, vga_vs=1, vga_de=0, rgb=0; frame_start on clock 0 and every 242 clocks.
- Free run, 3 frames → hs active 2 clocks of every 22, vs active 22 clocks of every 242, vga_de high 128 clocks per frame, frame_cnt=3.
- mode=0 → each bar is 2 pixels wide: x=0..1 gives FFFFFF, x=2..3 gives FFFF00, …, x=14..15 gives 000000.
- mode changed from 0 to 2 at pixel (5,3) → the rest of that frame stays colour bar; at the next frame, pixel (x=7, y=2) is r=07, g=02, b=09.
- mode=3 with ext_rgb = {8'hA5, xpos[7:0], ypos[7:0]} driven one clock after the request → pixel (4,6) out is A50406, aligned with vga_de.
- rst_n pulsed low at mid-frame (v=5) → all outputs at reset values within the same clock; the restart gives frame_start immediately and frame_cnt=0.
